// File: rtl/contador_sumador_param_if.sv
// contador_sumador_param_if
//   Bundles the operation bus of one contador_sumador_param slice.
//   The master side drives the command and operands. The slave side,
//   which is the arithmetic slice, returns the result and its flags.
//   Clock and reset are not part of the bundle.
//
//   ENB   : enable. 0 freezes all registered state.
//   MODO  : operation select.
//   A, B  : operands. A is also the load value; B is also the step value.
//   RCI   : ripple carry/borrow in.
//   Q     : registered result.
//   RCO   : registered carry/borrow out.
//   OVF   : sticky overflow flag.
//   ZERO  : combinational, high when Q is zero.
interface contador_sumador_param_if #(
  parameter int WIDTH = 4
);
  logic             ENB;
  logic [2:0]       MODO;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             RCI;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             OVF;
  logic             ZERO;

  modport master (
    output ENB, MODO, A, B, RCI,
    input  Q, RCO, OVF, ZERO
  );

  modport slave (
    input  ENB, MODO, A, B, RCI,
    output Q, RCO, OVF, ZERO
  );
endinterface

// File: rtl/contador_sumador_param.sv
// contador_sumador_param
//   N-bit registered arithmetic slice. It provides:
//     - one-shot A+B and A-B operations
//     - load
//     - accumulate up/down with carry/borrow in
//     - optional saturation
//     - a sticky overflow flag and a zero flag
//   Slices can be cascaded: the RCO of one slice drives the RCI of the
//   next slice.
//
//   Ports:
//     CLK   : clock. All state updates on the rising edge.
//     RESET : synchronous, active-high. Clears Q, RCO and OVF.
//     bus   : contador_sumador_param_if.slave, which carries
//             ENB, MODO, A, B and RCI in, and Q, RCO, OVF and ZERO out.
//
//   Parameters:
//     WIDTH : data width (>= 2).
//     SAT   : 1 = accumulate modes clamp at all-ones/zero; 0 = wrap.
module contador_sumador_param #(
  parameter int WIDTH = 4,
  parameter int SAT   = 0
) (
  input logic                      CLK,
  input logic                      RESET,
  contador_sumador_param_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_ADD  = 3'b001;
  localparam logic [2:0] MODE_SUB  = 3'b010;
  localparam logic [2:0] MODE_CLR  = 3'b011;
  localparam logic [2:0] MODE_LOAD = 3'b100;
  localparam logic [2:0] MODE_UP   = 3'b101;
  localparam logic [2:0] MODE_DOWN = 3'b110;

  // Unsigned x + y + cin at WIDTH+1 bits. The MSB is the carry out.
  function automatic logic [WIDTH:0] add_ext(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin
  );
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  endfunction

  // x - y - bin at WIDTH+1 bits, in two's complement.
  // The result lies in [-2^WIDTH, 2^WIDTH-1]. The MSB is therefore
  // exactly the borrow, that is, x < y + bin.
  function automatic logic [WIDTH:0] sub_ext(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             bin
  );
    return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bin};
  endfunction

  // Clamp on carry when saturation is enabled.
  function automatic logic [WIDTH-1:0] sat_up(
    input logic [WIDTH-1:0] sum,
    input logic             carry
  );
    if ((SAT != 0) && carry) return {WIDTH{1'b1}};
    return sum;
  endfunction

  // Clamp on borrow when saturation is enabled.
  function automatic logic [WIDTH-1:0] sat_down(
    input logic [WIDTH-1:0] diff,
    input logic             borrow
  );
    if ((SAT != 0) && borrow) return {WIDTH{1'b0}};
    return diff;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   add_ab;
  logic [WIDTH:0]   sub_ab;
  logic [WIDTH:0]   acc_up;
  logic [WIDTH:0]   acc_dn;

  // Operand paths are computed unconditionally. MODO only selects
  // among them.
  always_comb begin
    add_ab = add_ext(bus.A, bus.B, bus.RCI);
    sub_ab = sub_ext(bus.A, bus.B, bus.RCI);
    acc_up = add_ext(q_q,   bus.B, bus.RCI);
    acc_dn = sub_ext(q_q,   bus.B, bus.RCI);
  end

  always_comb begin
    q_d   = q_q;
    rco_d = rco_q;
    ovf_d = ovf_q;
    if (bus.ENB) begin
      case (bus.MODO)
        MODE_ADD: begin
          q_d   = add_ab[WIDTH-1:0];
          rco_d = add_ab[WIDTH];
        end
        MODE_SUB: begin
          q_d   = sub_ab[WIDTH-1:0];
          rco_d = sub_ab[WIDTH];
        end
        MODE_CLR: begin
          q_d   = '0;
          rco_d = 1'b0;
          ovf_d = 1'b0;
        end
        MODE_LOAD: begin
          q_d   = bus.A;
          rco_d = 1'b0;
        end
        // Only the accumulate modes feed the sticky overflow flag.
        // The one-shot add/sub report their carry on RCO alone.
        MODE_UP: begin
          q_d   = sat_up(acc_up[WIDTH-1:0], acc_up[WIDTH]);
          rco_d = acc_up[WIDTH];
          ovf_d = ovf_q | acc_up[WIDTH];
        end
        MODE_DOWN: begin
          q_d   = sat_down(acc_dn[WIDTH-1:0], acc_dn[WIDTH]);
          rco_d = acc_dn[WIDTH];
          ovf_d = ovf_q | acc_dn[WIDTH];
        end
        // MODE_HOLD and the reserved encoding 111 keep the state.
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q   <= '0;
      rco_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.RCO  = rco_q;
  assign bus.OVF  = ovf_q;
  assign bus.ZERO = (q_q == '0);

endmodule

// File: tb/tb_contador_sumador_param.sv
module tb_contador_sumador_param;

  logic CLK;
  logic RESET;

  contador_sumador_param_if #(.WIDTH(8)) if_s0 ();
  contador_sumador_param_if #(.WIDTH(8)) if_s1 ();
  contador_sumador_param_if #(.WIDTH(4)) if_lo ();
  contador_sumador_param_if #(.WIDTH(4)) if_hi ();

  contador_sumador_param #(.WIDTH(8), .SAT(0)) u_s0 (.CLK(CLK), .RESET(RESET), .bus(if_s0));
  contador_sumador_param #(.WIDTH(8), .SAT(1)) u_s1 (.CLK(CLK), .RESET(RESET), .bus(if_s1));
  contador_sumador_param #(.WIDTH(4), .SAT(0)) u_lo (.CLK(CLK), .RESET(RESET), .bus(if_lo));
  contador_sumador_param #(.WIDTH(4), .SAT(0)) u_hi (.CLK(CLK), .RESET(RESET), .bus(if_hi));

  // Cascade: the low slice's carry out feeds the high slice's carry in.
  assign if_hi.RCI = if_lo.RCO;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state for the two 8-bit slices. Index 0 wraps; index 1 saturates.
  int mq   [2];
  bit mrco [2];
  bit movf [2];

  typedef struct {
    logic       rst;
    logic       enb;
    logic [2:0] modo;
    logic [7:0] a;
    logic [7:0] b;
    logic       rci;
    logic [7:0] q;
    logic       rco;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [31:0] pk8(input logic [7:0] q, input logic rco,
                                      input logic ovf, input logic zero);
    return {21'd0, q, rco, ovf, zero};
  endfunction

  function automatic logic [31:0] pk4(input logic [3:0] q, input logic rco);
    return {27'd0, q, rco};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Plain-arithmetic model of one edge, applied to both 8-bit slices.
  task automatic model_step(input bit rst, input bit enb, input logic [2:0] modo,
                            input int a, input int b, input bit rci);
    for (int k = 0; k < 2; k++) begin
      int t;
      bit sat;
      sat = (k == 1);
      if (rst) begin
        mq[k] = 0; mrco[k] = 0; movf[k] = 0;
      end else if (enb) begin
        case (modo)
          3'd1: begin t = a + b + int'(rci); mrco[k] = (t >= 256); mq[k] = t % 256; end
          3'd2: begin t = a - b - int'(rci); mrco[k] = (t < 0); mq[k] = (t + 256) % 256; end
          3'd3: begin mq[k] = 0; mrco[k] = 0; movf[k] = 0; end
          3'd4: begin mq[k] = a; mrco[k] = 0; end
          3'd5: begin
            t = mq[k] + b + int'(rci);
            mrco[k] = (t >= 256);
            mq[k] = (sat && mrco[k]) ? 255 : t % 256;
            if (mrco[k]) movf[k] = 1;
          end
          3'd6: begin
            t = mq[k] - b - int'(rci);
            mrco[k] = (t < 0);
            mq[k] = (sat && mrco[k]) ? 0 : (t + 256) % 256;
            if (mrco[k]) movf[k] = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  // Drive both 8-bit slices for one edge, advance the model, and
  // return 1 time unit after the edge.
  task automatic step(input bit rst, input bit enb, input logic [2:0] modo,
                      input logic [7:0] a, input logic [7:0] b, input bit rci);
    RESET      = rst;
    if_s0.ENB  = enb;  if_s1.ENB  = enb;
    if_s0.MODO = modo; if_s1.MODO = modo;
    if_s0.A    = a;    if_s1.A    = a;
    if_s0.B    = b;    if_s1.B    = b;
    if_s0.RCI  = rci;  if_s1.RCI  = rci;
    @(posedge CLK);
    model_step(rst, enb, modo, int'(a), int'(b), rci);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_s0"}, pk8(if_s0.Q, if_s0.RCO, if_s0.OVF, if_s0.ZERO),
        pk8(mq[0][7:0], mrco[0], movf[0], mq[0] == 0));
    chk({tag, "_s1"}, pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO),
        pk8(mq[1][7:0], mrco[1], movf[1], mq[1] == 0));
  endtask

  initial begin
    // Expected values for the wrapping slice (SAT=0).
    //            rst   enb   modo   a      b      rci   q      rco   ovf   zero
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 3'd1, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'd2, 8'h04, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'd2, 8'h01, 8'h04, 1'b1, 8'hFC, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd4, 8'hFE, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'd4, 8'h55, 8'h00, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd1, 8'hFF, 8'hFF, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd3, 8'hFF, 8'hFF, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'd0, 8'h12, 8'h34, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'd7, 8'h12, 8'h34, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 3'd1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 3'd4, 8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 3'd5, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    // The 4-bit slices stay idle until the cascade section.
    if_lo.ENB = 1'b0; if_lo.MODO = 3'd0; if_lo.A = 4'h0; if_lo.B = 4'h0; if_lo.RCI = 1'b0;
    if_hi.ENB = 1'b0; if_hi.MODO = 3'd0; if_hi.A = 4'h0; if_hi.B = 4'h0;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rst, vecs[i].enb, vecs[i].modo, vecs[i].a, vecs[i].b, vecs[i].rci);
      chk($sformatf("vec%0d", i), pk8(if_s0.Q, if_s0.RCO, if_s0.OVF, if_s0.ZERO),
          pk8(vecs[i].q, vecs[i].rco, vecs[i].ovf, vecs[i].zero));
    end

    // Saturating slice: the down count clamps at zero, then clear drops OVF.
    step(1'b0, 1'b1, 3'd4, 8'h02, 8'h00, 1'b0);
    chk("sat_load", pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO), pk8(8'h02, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 3'd6, 8'h00, 8'h03, 1'b0);
    chk("sat_down", pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO), pk8(8'h00, 1'b1, 1'b1, 1'b1));
    chk("wrap_down", pk8(if_s0.Q, if_s0.RCO, if_s0.OVF, if_s0.ZERO), pk8(8'hFF, 1'b1, 1'b1, 1'b0));
    step(1'b0, 1'b1, 3'd6, 8'h00, 8'h03, 1'b0);
    chk("sat_down2", pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO), pk8(8'h00, 1'b1, 1'b1, 1'b1));
    step(1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 1'b0);
    chk("sat_clear", pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO), pk8(8'h00, 1'b0, 1'b0, 1'b1));

    // Saturating slice: the up count clamps at all ones.
    step(1'b0, 1'b1, 3'd4, 8'hFE, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd5, 8'h00, 8'h05, 1'b0);
    chk("sat_up", pk8(if_s1.Q, if_s1.RCO, if_s1.OVF, if_s1.ZERO), pk8(8'hFF, 1'b1, 1'b1, 1'b0));
    chk("wrap_up", pk8(if_s0.Q, if_s0.RCO, if_s0.OVF, if_s0.ZERO), pk8(8'h03, 1'b1, 1'b1, 1'b0));

    // Randomized traffic, checked against the model.
    for (int n = 0; n < 400; n++) begin
      bit         r_rst, r_enb, r_rci;
      logic [2:0] r_modo;
      logic [7:0] r_a, r_b;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_enb  = ($urandom_range(0, 7) != 0);
      r_modo = 3'($urandom_range(0, 7));
      r_a    = 8'($urandom_range(0, 255));
      r_b    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      r_rci  = 1'($urandom_range(0, 1));
      step(r_rst, r_enb, r_modo, r_a, r_b, r_rci);
      cmp_model($sformatf("rnd%0d", n));
    end

    // Freeze the 8-bit slices, then exercise the 4-bit cascade.
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    if_lo.ENB = 1'b1; if_lo.MODO = 3'd3;
    if_hi.ENB = 1'b1; if_hi.MODO = 3'd3;
    @(posedge CLK); #1;
    chk("casc_clear", {if_hi.Q, if_lo.Q}, 8'h00);
    if_lo.MODO = 3'd1; if_lo.A = 4'hF; if_lo.B = 4'h1; if_lo.RCI = 1'b0;
    if_hi.MODO = 3'd1; if_hi.A = 4'h0; if_hi.B = 4'h0;
    @(posedge CLK); #1;
    chk("casc_lo_e1", pk4(if_lo.Q, if_lo.RCO), pk4(4'h0, 1'b1));
    chk("casc_e1", {if_hi.Q, if_lo.Q}, 8'h00);
    @(posedge CLK); #1;
    chk("casc_e2", {if_hi.Q, if_lo.Q}, 8'h10);
    if_lo.MODO = 3'd2; if_lo.A = 4'h0; if_lo.B = 4'h0; if_lo.RCI = 1'b1;
    if_hi.ENB  = 1'b0;
    @(posedge CLK); #1;
    chk("w4_borrow", pk4(if_lo.Q, if_lo.RCO), pk4(4'hF, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
